// File: rtl/hd44780_lcd_responder.sv
// HD44780-compatible character-LCD responder (device end of the LCD bus).
// Holds DDRAM, address counter and busy flag; answers status/data reads.
module hd44780_lcd_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_data_in,
  output logic [7:0] LCD_data_out,
  output logic       LCD_data_oe,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_char,
  output logic       busy,
  output logic       display_on,
  output logic       busy_violation
);

  localparam int MAXC =
    (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BUSY_LD = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LD  = CW'(CLEAR_CYCLES - 1);

  function automatic logic f_valid(input logic [6:0] a);
    return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
  endfunction

  // Lines are packed back to back: 0x00-0x27 then 0x40-0x67.
  function automatic logic [6:0] f_idx(input logic [6:0] a);
    return a[6] ? (7'(a[5:0]) + 7'd40) : a;
  endfunction

  function automatic logic [6:0] f_adv(
    input logic [6:0] a,
    input logic       up,
    input logic       cg
  );
    if (cg)
      return {1'b0, up ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
    if (up) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h40) return 7'h27;
    if (a == 7'h00) return 7'h67;
    return a - 7'd1;
  endfunction

  logic       r_e_s1, r_e_s2, r_e_d;
  logic       r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2;
  logic [7:0] r_d_s1, r_d_s2;
  logic       r_rs_c, r_rw_c;
  logic [7:0] r_d_c;
  logic [6:0] r_ac;
  logic       r_id, r_cg, r_don, r_viol, r_oe;
  logic [7:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic       r_ld;
  logic [7:0] r_ram [0:79];

  logic          w_e_rise, w_e_fall, w_busy;
  logic [7:0]    w_ram_ac, w_rd_val;
  logic [6:0]    w_ac_nxt;
  logic          w_id_nxt, w_cg_nxt, w_don_nxt;
  logic          w_wen, w_clr, w_ld, w_viol;
  logic [CW-1:0] w_ld_val;

  assign w_e_rise = r_e_s2 & ~r_e_d;
  assign w_e_fall = ~r_e_s2 & r_e_d;
  assign w_busy   = r_ld | (r_cnt != '0);

  // Two-flop synchronizers on every bus input, plus E delay for edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e_s1  <= 1'b0;
      r_e_s2  <= 1'b0;
      r_e_d   <= 1'b0;
      r_rs_s1 <= 1'b0;
      r_rs_s2 <= 1'b0;
      r_rw_s1 <= 1'b0;
      r_rw_s2 <= 1'b0;
      r_d_s1  <= 8'h00;
      r_d_s2  <= 8'h00;
    end else begin
      r_e_s1  <= LCD_E;
      r_e_s2  <= r_e_s1;
      r_e_d   <= r_e_s2;
      r_rs_s1 <= LCD_RS;
      r_rs_s2 <= r_rs_s1;
      r_rw_s1 <= LCD_RW;
      r_rw_s2 <= r_rw_s1;
      r_d_s1  <= LCD_data_in;
      r_d_s2  <= r_d_s1;
    end
  end

  // Hold RS/RW/data while E is high so E_fall executes stable values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rs_c <= 1'b0;
      r_rw_c <= 1'b0;
      r_d_c  <= 8'h00;
    end else if (r_e_s2) begin
      r_rs_c <= r_rs_s2;
      r_rw_c <= r_rw_s2;
      r_d_c  <= r_d_s2;
    end
  end

  // Read data source: status word or DDRAM at the address counter.
  always_comb begin
    w_ram_ac = 8'h00;
    if (f_valid(r_ac) && !r_cg)
      w_ram_ac = r_ram[f_idx(r_ac)];
    w_rd_val = r_rs_s2 ? w_ram_ac : {w_busy, r_ac};
  end

  // Execute write strobes and data-read advances at E_fall.
  always_comb begin
    w_ac_nxt  = r_ac;
    w_id_nxt  = r_id;
    w_cg_nxt  = r_cg;
    w_don_nxt = r_don;
    w_wen     = 1'b0;
    w_clr     = 1'b0;
    w_ld      = 1'b0;
    w_viol    = 1'b0;
    w_ld_val  = BUSY_LD;
    if (w_e_fall && !r_rw_c && w_busy) begin
      w_viol = 1'b1;
    end else if (w_e_fall && !r_rw_c) begin
      w_ld = 1'b1;
      if (r_rs_c) begin
        w_wen    = ~r_cg & f_valid(r_ac);
        w_ac_nxt = f_adv(r_ac, r_id, r_cg);
      end else begin
        unique casez (r_d_c)
          8'b1???????: begin
            w_ac_nxt = r_d_c[6:0];
            w_cg_nxt = 1'b0;
          end
          8'b01??????: begin
            w_ac_nxt = {1'b0, r_d_c[5:0]};
            w_cg_nxt = 1'b1;
          end
          8'b001?????: ;
          8'b0001????: begin
            if (!r_d_c[3])
              w_ac_nxt = f_adv(r_ac, r_d_c[2], r_cg);
          end
          8'b00001???: w_don_nxt = r_d_c[2];
          8'b000001??: w_id_nxt = r_d_c[1];
          8'b0000001?: begin
            w_ac_nxt = 7'h00;
            w_cg_nxt = 1'b0;
          end
          8'b00000001: begin
            w_clr    = 1'b1;
            w_ac_nxt = 7'h00;
            w_id_nxt = 1'b1;
            w_cg_nxt = 1'b0;
            w_ld_val = CLR_LD;
          end
          default: w_ld = 1'b0;
        endcase
      end
    end else if (w_e_fall && r_rs_c) begin
      w_ac_nxt = f_adv(r_ac, r_id, r_cg);
    end
  end

  // Architectural state, read latch and output enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ac   <= 7'h00;
      r_id   <= 1'b1;
      r_cg   <= 1'b0;
      r_don  <= 1'b0;
      r_viol <= 1'b0;
      r_rd   <= 8'h00;
      r_oe   <= 1'b0;
    end else begin
      r_ac  <= w_ac_nxt;
      r_id  <= w_id_nxt;
      r_cg  <= w_cg_nxt;
      r_don <= w_don_nxt;
      r_oe  <= r_e_s2 & r_rw_s2;
      if (w_viol)
        r_viol <= 1'b1;
      if (w_e_rise)
        r_rd <= w_rd_val;
    end
  end

  // Busy counter; the load cycle itself counts as the first busy cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_ld  <= 1'b0;
    end else if (w_ld) begin
      r_cnt <= w_ld_val;
      r_ld  <= 1'b1;
    end else begin
      r_ld <= 1'b0;
      if (!r_ld && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // DDRAM: 80 characters, filled with spaces by reset and Clear Display.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 80; i++)
        r_ram[i] <= 8'h20;
    end else if (w_clr) begin
      for (int i = 0; i < 80; i++)
        r_ram[i] <= 8'h20;
    end else if (w_wen) begin
      r_ram[f_idx(r_ac)] <= r_d_c;
    end
  end

  // Scoreboard read port.
  always_comb begin
    dbg_char = 8'h00;
    if (f_valid(dbg_addr))
      dbg_char = r_ram[f_idx(dbg_addr)];
  end

  assign LCD_data_out   = r_rd;
  assign LCD_data_oe    = r_oe;
  assign busy           = w_busy;
  assign display_on     = r_don;
  assign busy_violation = r_viol;

endmodule

// File: tb/tb_hd44780_lcd_responder.sv
// Directed-vector bench for hd44780_lcd_responder.
// Small busy parameters keep the run short.
module tb_hd44780_lcd_responder;

  localparam int BC = 20;
  localparam int CC = 60;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       LCD_E = 1'b0;
  logic       LCD_RS = 1'b0;
  logic       LCD_RW = 1'b0;
  logic [7:0] LCD_data_in = 8'h00;
  logic [7:0] LCD_data_out;
  logic       LCD_data_oe;
  logic [6:0] dbg_addr = 7'h00;
  logic [7:0] dbg_char;
  logic       busy;
  logic       display_on;
  logic       busy_violation;

  int n_vec = 0;
  int n_miss = 0;

  hd44780_lcd_responder #(
    .BUSY_CYCLES (BC),
    .CLEAR_CYCLES(CC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .LCD_E         (LCD_E),
    .LCD_RS        (LCD_RS),
    .LCD_RW        (LCD_RW),
    .LCD_data_in   (LCD_data_in),
    .LCD_data_out  (LCD_data_out),
    .LCD_data_oe   (LCD_data_oe),
    .dbg_addr      (dbg_addr),
    .dbg_char      (dbg_char),
    .busy          (busy),
    .display_on    (display_on),
    .busy_violation(busy_violation)
  );

  always #5 clk = ~clk;

  // One E strobe, 5 clk high; returns at the negedge where E drops.
  task automatic pulse(input logic rs, input logic rw,
                       input logic [7:0] d,
                       output logic [7:0] rd, output logic oe);
    @(negedge clk);
    LCD_RS = rs;
    LCD_RW = rw;
    LCD_data_in = d;
    LCD_E = 1'b1;
    repeat (5) @(negedge clk);
    rd = LCD_data_out;
    oe = LCD_data_oe;
    LCD_E = 1'b0;
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    logic [7:0] x;
    logic o;
    pulse(rs, 1'b0, d, x, o);
    repeat (4) @(negedge clk);
  endtask

  task automatic rdop(input logic rs, output logic [7:0] v,
                      output logic o);
    pulse(rs, 1'b1, 8'h00, v, o);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle;
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!done) begin
      n_miss++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_miss++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    n_vec++;
    if ({LCD_data_oe, LCD_data_out} !== 9'h000) begin
      n_miss++;
      $display("FAIL rst_bus: got %h want 000",
               {LCD_data_oe, LCD_data_out});
    end
    n_vec++;
    if ({display_on, busy_violation} !== 2'b00) begin
      n_miss++;
      $display("FAIL rst_flags: got %b want 00",
               {display_on, busy_violation});
    end
    dbg_addr = 7'h00;
    #1;
    n_vec++;
    if (dbg_char !== 8'h20) begin
      n_miss++;
      $display("FAIL rst_ram: got %h want 20", dbg_char);
    end
    dbg_addr = 7'h28;
    #1;
    n_vec++;
    if (dbg_char !== 8'h00) begin
      n_miss++;
      $display("FAIL rst_inval: got %h want 00", dbg_char);
    end
  endtask

  task automatic test_status_read;
    logic [7:0] v;
    logic o;
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h00) begin
      n_miss++;
      $display("FAIL st_val: got %h want 00", v);
    end
    n_vec++;
    if (o !== 1'b1) begin
      n_miss++;
      $display("FAIL st_oe_hi: got %b want 1", o);
    end
    n_vec++;
    if ({LCD_data_oe, busy} !== 2'b00) begin
      n_miss++;
      $display("FAIL st_oe_lo: got %b want 00",
               {LCD_data_oe, busy});
    end
  endtask

  task automatic test_data_write;
    logic [7:0] v;
    logic o;
    wr(1'b0, 8'h80);
    wait_idle();
    wr(1'b1, 8'h41);
    dbg_addr = 7'h00;
    #1;
    n_vec++;
    if (dbg_char !== 8'h41) begin
      n_miss++;
      $display("FAIL dw_ram: got %h want 41", dbg_char);
    end
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h81) begin
      n_miss++;
      $display("FAIL dw_st_busy: got %h want 81", v);
    end
    wait_idle();
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h01) begin
      n_miss++;
      $display("FAIL dw_st_idle: got %h want 01", v);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    logic o;
    wr(1'b0, 8'hA7);
    wait_idle();
    wr(1'b1, 8'h42);
    wait_idle();
    wr(1'b1, 8'h43);
    wait_idle();
    dbg_addr = 7'h27;
    #1;
    n_vec++;
    if (dbg_char !== 8'h42) begin
      n_miss++;
      $display("FAIL wr_27: got %h want 42", dbg_char);
    end
    dbg_addr = 7'h40;
    #1;
    n_vec++;
    if (dbg_char !== 8'h43) begin
      n_miss++;
      $display("FAIL wr_40: got %h want 43", dbg_char);
    end
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h41) begin
      n_miss++;
      $display("FAIL wr_ac: got %h want 41", v);
    end
  endtask

  task automatic test_decrement;
    logic [7:0] v;
    logic o;
    wr(1'b0, 8'h04);
    wait_idle();
    wr(1'b0, 8'h80);
    wait_idle();
    wr(1'b1, 8'h44);
    wait_idle();
    dbg_addr = 7'h00;
    #1;
    n_vec++;
    if (dbg_char !== 8'h44) begin
      n_miss++;
      $display("FAIL dec_ram: got %h want 44", dbg_char);
    end
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h67) begin
      n_miss++;
      $display("FAIL dec_ac: got %h want 67", v);
    end
    wr(1'b0, 8'h06);
    wait_idle();
  endtask

  task automatic test_display_cursor;
    logic [7:0] v;
    logic o;
    wr(1'b0, 8'h0C);
    wait_idle();
    n_vec++;
    if (display_on !== 1'b1) begin
      n_miss++;
      $display("FAIL disp_on: got %b want 1", display_on);
    end
    wr(1'b0, 8'h08);
    wait_idle();
    n_vec++;
    if (display_on !== 1'b0) begin
      n_miss++;
      $display("FAIL disp_off: got %b want 0", display_on);
    end
    wr(1'b0, 8'h14);
    wait_idle();
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h00) begin
      n_miss++;
      $display("FAIL cur_right: got %h want 00", v);
    end
    wr(1'b0, 8'h10);
    wait_idle();
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h67) begin
      n_miss++;
      $display("FAIL cur_left: got %h want 67", v);
    end
    wr(1'b0, 8'h4F);
    wait_idle();
    rdop(1'b1, v, o);
    n_vec++;
    if (v !== 8'h00) begin
      n_miss++;
      $display("FAIL cg_read: got %h want 00", v);
    end
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h10) begin
      n_miss++;
      $display("FAIL cg_ac: got %h want 10", v);
    end
    wr(1'b0, 8'h80);
    wait_idle();
  endtask

  task automatic test_busy_boundary;
    logic [7:0] x;
    logic o;
    int cnt;
    pulse(1'b0, 1'b0, 8'h06, x, o);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    n_vec++;
    if (cnt != BC) begin
      n_miss++;
      $display("FAIL busy_len: got %0d want %0d", cnt, BC);
    end
    pulse(1'b0, 1'b0, 8'h90, x, o);
    repeat (21 - 6) @(negedge clk);
    pulse(1'b1, 1'b0, 8'h58, x, o);
    repeat (4) @(negedge clk);
    dbg_addr = 7'h10;
    #1;
    n_vec++;
    if ({busy_violation, dbg_char} !== 9'h058) begin
      n_miss++;
      $display("FAIL bnd_accept: got %h want 058",
               {busy_violation, dbg_char});
    end
    wait_idle();
    pulse(1'b0, 1'b0, 8'h92, x, o);
    repeat (20 - 6) @(negedge clk);
    pulse(1'b1, 1'b0, 8'h59, x, o);
    repeat (4) @(negedge clk);
    dbg_addr = 7'h12;
    #1;
    n_vec++;
    if ({busy_violation, dbg_char} !== 9'h120) begin
      n_miss++;
      $display("FAIL bnd_reject: got %h want 120",
               {busy_violation, dbg_char});
    end
    wait_idle();
  endtask

  task automatic test_mid_reset;
    wr(1'b0, 8'h0C);
    n_vec++;
    if ({busy, display_on} !== 2'b11) begin
      n_miss++;
      $display("FAIL mr_pre: got %b want 11",
               {busy, display_on});
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, display_on, busy_violation} !== 3'b000) begin
      n_miss++;
      $display("FAIL mr_post: got %b want 000",
               {busy, display_on, busy_violation});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clear;
    logic [7:0] v;
    logic [7:0] x;
    logic o;
    int cnt;
    int bad;
    wr(1'b0, 8'h04);
    wait_idle();
    wr(1'b0, 8'hC3);
    wait_idle();
    wr(1'b1, 8'h77);
    wait_idle();
    pulse(1'b0, 1'b0, 8'h01, x, o);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    n_vec++;
    if (cnt != CC) begin
      n_miss++;
      $display("FAIL clr_len: got %0d want %0d", cnt, CC);
    end
    bad = 0;
    for (int a = 0; a < 128; a++) begin
      dbg_addr = 7'(a);
      #1;
      if ((a <= 'h27) || (a >= 'h40 && a <= 'h67))
        if (dbg_char !== 8'h20) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_miss++;
      $display("FAIL clr_ram: got %0d bad want 0", bad);
    end
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h00) begin
      n_miss++;
      $display("FAIL clr_ac: got %h want 00", v);
    end
    wr(1'b1, 8'h31);
    wait_idle();
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h01) begin
      n_miss++;
      $display("FAIL clr_id: got %h want 01", v);
    end
    pulse(1'b0, 1'b0, 8'h01, x, o);
    repeat (10) @(negedge clk);
    wr(1'b1, 8'h55);
    n_vec++;
    if ({busy, busy_violation} !== 2'b11) begin
      n_miss++;
      $display("FAIL clr_viol: got %b want 11",
               {busy, busy_violation});
    end
    wait_idle();
    dbg_addr = 7'h00;
    #1;
    n_vec++;
    if (dbg_char !== 8'h20) begin
      n_miss++;
      $display("FAIL clr_drop: got %h want 20", dbg_char);
    end
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h00) begin
      n_miss++;
      $display("FAIL clr_drop_ac: got %h want 00", v);
    end
  endtask

  task automatic test_read_data;
    logic [7:0] v;
    logic o;
    wr(1'b0, 8'h85);
    wait_idle();
    wr(1'b1, 8'h6B);
    wait_idle();
    wr(1'b0, 8'h85);
    wait_idle();
    rdop(1'b1, v, o);
    n_vec++;
    if ({o, v} !== 9'h16B) begin
      n_miss++;
      $display("FAIL rd_data: got %h want 16b", {o, v});
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_miss++;
      $display("FAIL rd_busy: got %b want 0", busy);
    end
    rdop(1'b0, v, o);
    n_vec++;
    if (v !== 8'h06) begin
      n_miss++;
      $display("FAIL rd_ac: got %h want 06", v);
    end
    n_vec++;
    if (busy_violation !== 1'b1) begin
      n_miss++;
      $display("FAIL rd_sticky: got %b want 1", busy_violation);
    end
  endtask

  initial begin
    test_reset();
    test_status_read();
    test_data_write();
    test_wrap();
    test_decrement();
    test_display_cursor();
    test_busy_boundary();
    test_mid_reset();
    test_clear();
    test_read_data();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hd44780_lcd_responder.md
# hd44780_lcd_responder

- Synthesizable HD44780-compatible character-LCD responder: the device end of the 16x2 LCD bus that the Qsys LCD controller slave drives.
- Samples LCD_E/LCD_RS/LCD_RW/data, executes the instruction subset, holds DDRAM, address counter and busy flag, and answers status/data reads.
- Used on-chip as a loopback target and in simulation as a bus-timing checker for the LCD driver software and hardware.

## Interface
Parameters:
- BUSY_CYCLES, 2000, busy duration in clk cycles after any executed non-clear instruction or data access (40 us at 50 MHz).
- CLEAR_CYCLES, 82000, busy duration after Clear Display (1.64 ms at 50 MHz).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- LCD_E  input  1  enable strobe from the bus master.
- LCD_RS  input  1  register select; 0 = instruction/status, 1 = data.
- LCD_RW  input  1  1 = read, 0 = write.
- LCD_data_in  input  8  data bus as seen by the responder.
- LCD_data_out  output  8  read data driven back to the master.
- LCD_data_oe  output  1  tri-state enable for LCD_data_out.
- dbg_addr  input  7  DDRAM address for the scoreboard read port.
- dbg_char  output  8  DDRAM[dbg_addr]; combinational; 0x00 for invalid addresses.
- busy  output  1  busy flag (BF).
- display_on  output  1  D bit from the last Display On/Off instruction.
- busy_violation  output  1  sticky; set when a write strobe completes while busy.

## Operation
- Input capture: two-flop synchronizer on LCD_E, LCD_RS, LCD_RW and LCD_data_in.
- E_rise / E_fall are single-cycle pulses from the synchronized E.
- RS, RW and data are held in a capture register on every cycle the synchronized E is 1. Execution uses the held values at E_fall.
- Write (RW=0) at E_fall, when busy=0. If busy=1, the write is ignored and busy_violation is set.
  - RS=1, data write: if AC is a valid DDRAM address, DDRAM[AC] = data. Then advance AC. Start BUSY_CYCLES.
  - RS=0, instruction decode, highest set bit wins:
    - 1xxxxxxx, Set DDRAM address: AC = d[6:0]; mode = DD.
    - 01xxxxxx, Set CGRAM address: mode = CG; AC = d[5:0]. CG data writes are discarded but still advance AC mod 64. CG reads return 0x00.
    - 001xxxxx, Function Set: accepted, no effect.
    - 0001SRxx: if S=0, move the cursor (AC advances in the direction of R). If S=1, no effect (display shift is not modelled).
    - 00001DCB, Display On/Off: display_on = D.
    - 000001IS, Entry Mode Set: ID = I; S ignored.
    - 0000001x, Return Home: AC = 0; mode = DD.
    - 00000001, Clear Display: all DDRAM = 0x20; AC = 0; ID = 1; mode = DD; busy for CLEAR_CYCLES instead of BUSY_CYCLES.
  - Every accepted instruction starts BUSY_CYCLES, except Clear Display.
- Read (RW=1), performed regardless of busy:
  - At E_rise, latch read_value. RS=0 gives {busy, AC[6:0]}. RS=1 gives DDRAM[AC] (0x00 if AC is invalid or mode = CG).
  - LCD_data_oe = 1 while the synchronized E is 1 and the captured RW is 1. LCD_data_out = read_value.
  - At E_fall, an RS=1 read advances AC. Busy is not changed.
- AC advance:
  - Valid DDRAM: 0x00-0x27 and 0x40-0x67.
  - ID=1: 0x27 -> 0x40, 0x67 -> 0x00, otherwise +1 mod 128.
  - ID=0: 0x40 -> 0x27, 0x00 -> 0x67, otherwise -1 mod 128.
- Busy counter: loaded with N-1 at execution. busy = (count != 0) or the load cycle. It decrements to 0.
- Reset values: all outputs 0. AC = 0, ID = 1, mode = DD, DDRAM all 0x20, counter 0, read_value 0.

## Timing
- Pin E rise -> LCD_data_oe = 1: 3 clk (2 sync + 1 register). Pin E fall -> oe = 0: 3 clk.
- Write executes 3 clk after pin E fall. busy is 1 in the same cycle the DDRAM/AC update becomes visible.
- busy is 1 for exactly BUSY_CYCLES (or CLEAR_CYCLES) cycles.
- A write strobe whose E_fall lands in the last busy cycle is a violation. One landing in the first cycle with busy=0 is accepted.
- E pulses shorter than 2 clk (after synchronization) produce no E_rise/E_fall pair and are not observed. Software-visible minimum pulse is 3 clk.
- Reset asserted mid-strobe or mid-busy: everything returns to reset values immediately. The following E_fall is ignored if the synchronized E was 0 at reset release.

## Test plan
- Reset, then status read -> LCD_data_out = 0x00, oe high for the E width, busy = 0.
- Write 0x80 (RS=0), wait for busy to clear, write 'A' = 0x41 (RS=1) -> dbg_char at 0x00 = 0x41. A following status read returns 0x81 while busy, 0x01 after BUSY_CYCLES.
- Set DDRAM 0x27, write 0x42, then 0x43 -> DDRAM[0x27] = 0x42, DDRAM[0x40] = 0x43, AC = 0x41.
- Entry mode 0x04, set DDRAM 0x00, write 0x44 -> DDRAM[0x00] = 0x44, AC = 0x67.
- Write 0x01 -> busy for CLEAR_CYCLES, all 80 dbg_char = 0x20, AC = 0. A data write issued 10 clk later is dropped and busy_violation = 1, held until reset.
- Set DDRAM 0x05, data read (RS=1, RW=1) -> DDRAM[0x05] returned. AC becomes 0x06, busy stays 0.
